stopwatch_core: RTL and testbench
=================================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter MIN_MAX, default 9, is the largest minutes value; legal range 1..9.
REQ-002 clk_in  input  1  system clock; all logic is on its rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 slow_clk  input  1  0.1 s period square wave from the clock divider, registered in the clk_in domain.
REQ-005 start_stop  input  1  one-cycle command pulse that toggles run/pause.
REQ-006 clear  input  1  one-cycle command pulse that zeroes the count and returns to IDLE.
REQ-007 tenths  output  4  BCD tenths-of-second digit, 0..9.
REQ-008 sec_ones  output  4  BCD seconds units digit, 0..9.
REQ-009 sec_tens  output  4  BCD seconds tens digit, 0..5.
REQ-010 minutes  output  4  BCD minutes digit, 0..MIN_MAX.
REQ-011 running  output  1  high while the state is RUN.
REQ-012 rollover  output  1  one-cycle pulse when the count wraps from MIN_MAX:59.9 to 0:00.0.

Function
REQ-013 A tick SHALL occur on any clk_in edge where slow_clk samples 1 and the internal previous-sample register (prev) holds 0; prev SHALL update to slow_clk on every edge.
REQ-014 The FSM SHALL have exactly three states:
- IDLE: count zero, not counting.
- RUN: counting.
- PAUSE: count held.
REQ-015 FSM transitions on start_stop SHALL be: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-016 clear SHALL force IDLE and zero all four digits on the next edge from any state.
REQ-017 clear SHALL take priority over start_stop and over a tick in the same cycle.
REQ-018 Counting SHALL use the current state: a tick in a cycle whose state is RUN SHALL be counted, even if start_stop is high in that cycle.
REQ-019 Each counted tick SHALL increment the count by 0.1 s, with digit updates registered on that same clk_in edge (zero-cycle latency from the tick edge).
REQ-020 BCD carry chain:
- tenths 9->0 carries into sec_ones.
- sec_ones 9->0 carries into sec_tens.
- sec_tens 5->0 carries into minutes.
- minutes MIN_MAX->0 wraps the whole count.
REQ-021 Every digit SHALL stay within its legal range at all times; no binary values outside BCD SHALL ever appear.
REQ-022 On the wrap from MIN_MAX:59.9 to 0:00.0, the state SHALL remain RUN and rollover SHALL be high for exactly the one cycle of the wrap edge.
REQ-023 running SHALL be registered and equal to (state==RUN).
REQ-024 Ticks in IDLE or PAUSE SHALL be ignored and SHALL not be queued.

Reset
REQ-025 On reset the block SHALL enter IDLE with all digits 0, running 0, rollover 0, and prev 1, so that a slow_clk already high after reset produces no tick.
REQ-026 reset SHALL override clear, start_stop and tick.
REQ-027 A reset asserted mid-count SHALL take effect on the next edge with no partial digit update.

Configuration
REQ-028 With macro STOPWATCH_LAP_EN defined, the block SHALL add input lap (1 bit, one-cycle pulse) and an internal lap_hold flag.
REQ-029 With STOPWATCH_LAP_EN defined, lap behaviour SHALL be:
- lap in RUN toggles lap_hold.
- While lap_hold is 1, the digit outputs show a snapshot captured on the setting edge, and internal counting continues.
- Clearing lap_hold returns the outputs to the live count.
- lap in IDLE or PAUSE is ignored.
- clear and reset force lap_hold to 0.
- Entering PAUSE leaves lap_hold unchanged.
REQ-030 Without STOPWATCH_LAP_EN, the lap port and logic SHALL be absent and the outputs SHALL always show the live count.

Verification
REQ-031 Reset with slow_clk held high, then 3 cycles -> digits 0:00.0, running 0, no tick counted.
REQ-032 start_stop, then 25 slow_clk rising edges -> 0:02.5, running 1; start_stop, then 10 more edges -> still 0:02.5, running 0.
REQ-033 With MIN_MAX=1, run 1199 ticks -> 1:59.9; 1 more tick -> 0:00.0, rollover high for exactly 1 cycle, running stays 1.
REQ-034 clear and start_stop in the same cycle while in RUN at 0:07.3 -> next edge shows IDLE and 0:00.0, running 0.
REQ-035 start_stop in the same cycle as a tick while in RUN at 0:00.4 -> count becomes 0:00.5, then PAUSE.
REQ-036 With STOPWATCH_LAP_EN defined: lap at 0:03.0, then 20 ticks -> outputs stay 0:03.0; second lap -> outputs show 0:05.0.

Source files
------------

// File: rtl/stopwatch_core.sv
// BCD stopwatch core (m:ss.t) driven by a 0.1 s slow_clk; three-state IDLE/RUN/PAUSE control.
// Optional lap-hold display freeze is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_core #(
  parameter int MIN_MAX = 9
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       slow_clk,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
`endif
  output logic [3:0] tenths,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] minutes,
  output logic       running,
  output logic       rollover
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] MIN_LAST = 4'(MIN_MAX);

  state_t      state_q;
  logic        prev_q;
  logic [15:0] count_q;   // {minutes, sec_tens, sec_ones, tenths}
  logic        running_q;
  logic        rollover_q;

  logic        tick;
  logic        advance;
  logic [15:0] count_inc;
  logic        wrap;
  logic [15:0] count_d;

  assign tick    = slow_clk & ~prev_q;
  assign advance = tick && (state_q == RUN);

  // BCD carry chain; >= comparisons keep any digit from leaving its range.
  always_comb begin
    count_inc = count_q;
    wrap      = 1'b0;
    if (count_q[3:0] >= 4'd9) begin
      count_inc[3:0] = 4'd0;
      if (count_q[7:4] >= 4'd9) begin
        count_inc[7:4] = 4'd0;
        if (count_q[11:8] >= 4'd5) begin
          count_inc[11:8] = 4'd0;
          if (count_q[15:12] >= MIN_LAST) begin
            count_inc[15:12] = 4'd0;
            wrap             = 1'b1;
          end else begin
            count_inc[15:12] = count_q[15:12] + 4'd1;
          end
        end else begin
          count_inc[11:8] = count_q[11:8] + 4'd1;
        end
      end else begin
        count_inc[7:4] = count_q[7:4] + 4'd1;
      end
    end else begin
      count_inc[3:0] = count_q[3:0] + 4'd1;
    end
  end

  assign count_d = advance ? count_inc : count_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= IDLE;
      prev_q     <= 1'b1;
      count_q    <= 16'd0;
      running_q  <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      prev_q     <= slow_clk;
      rollover_q <= 1'b0;
      if (clear) begin
        state_q   <= IDLE;
        count_q   <= 16'd0;
        running_q <= 1'b0;
      end else begin
        // The count follows the state held before this edge, so a tick
        // coinciding with start_stop in RUN is still counted.
        count_q    <= count_d;
        rollover_q <= advance && wrap;
        if (start_stop) begin
          unique case (state_q)
            IDLE: begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
            RUN: begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end
            PAUSE: begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
            default: begin
              state_q   <= IDLE;
              running_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        lap_hold_q;
  logic [15:0] snap_q;

  // The snapshot takes the count as it stands after the setting edge.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      lap_hold_q <= 1'b0;
      snap_q     <= 16'd0;
    end else if (clear) begin
      lap_hold_q <= 1'b0;
    end else if (lap && (state_q == RUN)) begin
      lap_hold_q <= ~lap_hold_q;
      if (!lap_hold_q) begin
        snap_q <= count_d;
      end
    end
  end

  assign tenths   = lap_hold_q ? snap_q[3:0]   : count_q[3:0];
  assign sec_ones = lap_hold_q ? snap_q[7:4]   : count_q[7:4];
  assign sec_tens = lap_hold_q ? snap_q[11:8]  : count_q[11:8];
  assign minutes  = lap_hold_q ? snap_q[15:12] : count_q[15:12];
`else
  assign tenths   = count_q[3:0];
  assign sec_ones = count_q[7:4];
  assign sec_tens = count_q[11:8];
  assign minutes  = count_q[15:12];
`endif

  assign running  = running_q;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core built with MIN_MAX=1.
// Lap scenario is exercised only when STOPWATCH_LAP_EN is defined.
module tb_stopwatch_core;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       slow_clk = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
  logic       lap = 1'b0;
`endif
  logic [3:0] tenths;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] minutes;
  logic       running;
  logic       rollover;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] disp;
  assign disp = {minutes, sec_tens, sec_ones, tenths};

  stopwatch_core #(.MIN_MAX(1)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .slow_clk   (slow_clk),
    .start_stop (start_stop),
    .clear      (clear),
`ifdef STOPWATCH_LAP_EN
    .lap        (lap),
`endif
    .tenths     (tenths),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .minutes    (minutes),
    .running    (running),
    .rollover   (rollover)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in) slow_clk = 1'b1;
      @(negedge clk_in) slow_clk = 1'b0;
    end
  endtask

  task automatic ss_pulse();
    @(negedge clk_in) start_stop = 1'b1;
    @(negedge clk_in) start_stop = 1'b0;
  endtask

  task automatic clear_pulse();
    @(negedge clk_in) clear = 1'b1;
    @(negedge clk_in) clear = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    slow_clk = 1'b1;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    repeat (3) @(negedge clk_in);
    n_checks++;
    if (disp !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_digits: got %h want %h", disp, 16'h0000);
    end
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_running: got %b want 0", running);
    end
    n_checks++;
    if (rollover !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rollover: got %b want 0", rollover);
    end
    slow_clk = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_run_pause();
    ss_pulse();
    tick_n(25);
    n_checks++;
    if (disp !== 16'h0025) begin
      n_fail++;
      $display("FAIL run_25: got %h want %h", disp, 16'h0025);
    end
    n_checks++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL run_running: got %b want 1", running);
    end
    ss_pulse();
    tick_n(10);
    n_checks++;
    if (disp !== 16'h0025) begin
      n_fail++;
      $display("FAIL pause_hold: got %h want %h", disp, 16'h0025);
    end
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_running: got %b want 0", running);
    end
    ss_pulse();
    tick_n(1);
    n_checks++;
    if (disp !== 16'h0026) begin
      n_fail++;
      $display("FAIL resume_no_queue: got %h want %h", disp, 16'h0026);
    end
    n_checks++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_running: got %b want 1", running);
    end
  endtask

  task automatic test_clear_priority();
    clear_pulse();
    n_checks++;
    if (disp !== 16'h0000 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_basic: got %h/%b want 0000/0", disp, running);
    end
    ss_pulse();
    tick_n(73);
    n_checks++;
    if (disp !== 16'h0073) begin
      n_fail++;
      $display("FAIL count_73: got %h want %h", disp, 16'h0073);
    end
    @(negedge clk_in);
    clear      = 1'b1;
    start_stop = 1'b1;
    slow_clk   = 1'b1;
    @(negedge clk_in);
    clear      = 1'b0;
    start_stop = 1'b0;
    slow_clk   = 1'b0;
    n_checks++;
    if (disp !== 16'h0000) begin
      n_fail++;
      $display("FAIL clear_prio_digits: got %h want %h", disp, 16'h0000);
    end
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_prio_running: got %b want 0", running);
    end
    tick_n(2);
    n_checks++;
    if (disp !== 16'h0000) begin
      n_fail++;
      $display("FAIL idle_ignores_ticks: got %h want %h", disp, 16'h0000);
    end
  endtask

  task automatic test_ss_with_tick();
    ss_pulse();
    tick_n(4);
    n_checks++;
    if (disp !== 16'h0004) begin
      n_fail++;
      $display("FAIL count_4: got %h want %h", disp, 16'h0004);
    end
    @(negedge clk_in);
    start_stop = 1'b1;
    slow_clk   = 1'b1;
    @(negedge clk_in);
    start_stop = 1'b0;
    slow_clk   = 1'b0;
    n_checks++;
    if (disp !== 16'h0005) begin
      n_fail++;
      $display("FAIL ss_tick_counted: got %h want %h", disp, 16'h0005);
    end
    n_checks++;
    if (running !== 1'b0) begin
      n_fail++;
      $display("FAIL ss_tick_paused: got %b want 0", running);
    end
    tick_n(3);
    n_checks++;
    if (disp !== 16'h0005) begin
      n_fail++;
      $display("FAIL pause_ignores_ticks: got %h want %h", disp, 16'h0005);
    end
  endtask

  task automatic test_reset_mid_count();
    clear_pulse();
    ss_pulse();
    tick_n(5);
    @(negedge clk_in);
    reset    = 1'b1;
    slow_clk = 1'b1;
    @(negedge clk_in);
    reset    = 1'b0;
    slow_clk = 1'b0;
    n_checks++;
    if (disp !== 16'h0000 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h/%b want 0000/0", disp, running);
    end
    tick_n(2);
    n_checks++;
    if (disp !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_to_idle: got %h want %h", disp, 16'h0000);
    end
  endtask

  task automatic test_rollover();
    clear_pulse();
    ss_pulse();
    tick_n(1199);
    n_checks++;
    if (disp !== 16'h1599) begin
      n_fail++;
      $display("FAIL count_1599: got %h want %h", disp, 16'h1599);
    end
    n_checks++;
    if (rollover !== 1'b0) begin
      n_fail++;
      $display("FAIL rollover_early: got %b want 0", rollover);
    end
    @(negedge clk_in) slow_clk = 1'b1;
    @(negedge clk_in);
    slow_clk = 1'b0;
    n_checks++;
    if (disp !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_digits: got %h want %h", disp, 16'h0000);
    end
    n_checks++;
    if (rollover !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_pulse: got %b want 1", rollover);
    end
    n_checks++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_running: got %b want 1", running);
    end
    @(negedge clk_in);
    n_checks++;
    if (rollover !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_pulse_width: got %b want 0", rollover);
    end
    tick_n(1);
    n_checks++;
    if (disp !== 16'h0001) begin
      n_fail++;
      $display("FAIL after_wrap: got %h want %h", disp, 16'h0001);
    end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    clear_pulse();
    ss_pulse();
    tick_n(30);
    @(negedge clk_in) lap = 1'b1;
    @(negedge clk_in) lap = 1'b0;
    n_checks++;
    if (disp !== 16'h0030) begin
      n_fail++;
      $display("FAIL lap_set: got %h want %h", disp, 16'h0030);
    end
    tick_n(20);
    n_checks++;
    if (disp !== 16'h0030) begin
      n_fail++;
      $display("FAIL lap_frozen: got %h want %h", disp, 16'h0030);
    end
    @(negedge clk_in) lap = 1'b1;
    @(negedge clk_in) lap = 1'b0;
    n_checks++;
    if (disp !== 16'h0050) begin
      n_fail++;
      $display("FAIL lap_release: got %h want %h", disp, 16'h0050);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_run_pause();
    test_clear_priority();
    test_ss_with_tick();
    test_reset_mid_count();
    test_rollover();
`ifdef STOPWATCH_LAP_EN
    test_lap();
`endif
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
